// File: rtl/key_debounce_n.sv
// key_debounce_n
//   Multi-channel key debouncer. Raw key levels are synchronised and sampled
//   on a shared slow tick. A level change is accepted only after
//   DEBOUNCE_TICKS consecutive agreeing samples. Accepted edges produce
//   one-CLK press and release pulses.
//
//   Build option: define KEY_REPEAT_EN to build per-channel auto-repeat.
//   A key held in the pressed state pulses key_repeat after HOLD_TICKS ticks,
//   and then every REPEAT_TICKS ticks. Without the macro, key_repeat is tied
//   to 0 and no hold counters exist.
//
// Ports
//   CLK          system clock, all state on the rising edge
//   RESET        asynchronous, active-high reset
//   din          raw asynchronous key levels (polarity set by ACTIVE_LOW)
//   key_state    debounced level per key, 1 = pressed
//   key_press    one-CLK pulse per accepted press
//   key_release  one-CLK pulse per accepted release
//   key_repeat   one-CLK pulse per auto-repeat event
//   key_any      OR of key_state
module key_debounce_n #(
  parameter int NUM_KEYS       = 5,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int ACTIVE_LOW     = 1,
  parameter int HOLD_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] din,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                key_any
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [DIV_W-1:0]    DIV_LAST     = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]    DEB_TARGET   = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [NUM_KEYS-1:0] RAW_RELEASED = {NUM_KEYS{ACTIVE_LOW != 0}};

`ifdef KEY_REPEAT_EN
  localparam int HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_TICKS - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_PRESSED,
    S_RELEASE_WAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. It resets to the raw "released" level, so a key
  // held through reset is seen as a new press.
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] sync_q1;
  logic [NUM_KEYS-1:0] sync_q2;
  logic [NUM_KEYS-1:0] pressed;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q1 <= RAW_RELEASED;
      sync_q2 <= RAW_RELEASED;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  assign pressed = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

  // ---------------------------------------------------------------------------
  // Shared sample-tick divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce FSMs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    state_t           st_q;
    state_t           st_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_d;
    logic             rel_d;
    logic             kstate_q;
    logic             kpress_q;
    logic             krel_q;

    // The count is at most DEBOUNCE_TICKS-1 in the wait states, so the
    // increment never reaches a value that would wrap.
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (tick) begin
        unique case (st_q)
          S_IDLE: begin
            if (pressed[g]) begin
              if (DEBOUNCE_TICKS == 1) begin
                st_d    = S_PRESSED;
                cnt_d   = '0;
                press_d = 1'b1;
              end else begin
                st_d  = S_PRESS_WAIT;
                cnt_d = CNT_W'(1);
              end
            end
          end
          S_PRESS_WAIT: begin
            if (pressed[g]) begin
              if (cnt_inc == DEB_TARGET) begin
                st_d    = S_PRESSED;
                cnt_d   = '0;
                press_d = 1'b1;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              st_d  = S_IDLE;
              cnt_d = '0;
            end
          end
          S_PRESSED: begin
            if (!pressed[g]) begin
              if (DEBOUNCE_TICKS == 1) begin
                st_d  = S_IDLE;
                cnt_d = '0;
                rel_d = 1'b1;
              end else begin
                st_d  = S_RELEASE_WAIT;
                cnt_d = CNT_W'(1);
              end
            end
          end
          S_RELEASE_WAIT: begin
            if (!pressed[g]) begin
              if (cnt_inc == DEB_TARGET) begin
                st_d  = S_IDLE;
                cnt_d = '0;
                rel_d = 1'b1;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              // A bounce back to pressed is not a new press, so no pulse.
              st_d  = S_PRESSED;
              cnt_d = '0;
            end
          end
          default: begin
            st_d  = S_IDLE;
            cnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        st_q     <= S_IDLE;
        cnt_q    <= '0;
        kstate_q <= 1'b0;
        kpress_q <= 1'b0;
        krel_q   <= 1'b0;
      end else begin
        st_q     <= st_d;
        cnt_q    <= cnt_d;
        kstate_q <= (st_d == S_PRESSED) || (st_d == S_RELEASE_WAIT);
        kpress_q <= press_d;
        krel_q   <= rel_d;
      end
    end

    assign key_state[g]   = kstate_q;
    assign key_press[g]   = kpress_q;
    assign key_release[g] = krel_q;

`ifdef KEY_REPEAT_EN
    // The hold counter runs only while the channel stays in PRESSED. The
    // tick that enters PRESSED counts as tick 0. rep_phase selects between
    // the initial hold interval and the repeat interval.
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              rep_phase_q;
    logic              rep_phase_d;
    logic              rep_d;
    logic              krep_q;

    always_comb begin
      hold_d      = hold_q;
      rep_phase_d = rep_phase_q;
      rep_d       = 1'b0;
      if ((st_q != S_PRESSED) || (st_d != S_PRESSED)) begin
        hold_d      = '0;
        rep_phase_d = 1'b0;
      end else if (tick) begin
        if (hold_q >= (rep_phase_q ? REP_LAST : HOLD_LAST)) begin
          rep_d       = 1'b1;
          hold_d      = '0;
          rep_phase_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        hold_q      <= '0;
        rep_phase_q <= 1'b0;
        krep_q      <= 1'b0;
      end else begin
        hold_q      <= hold_d;
        rep_phase_q <= rep_phase_d;
        krep_q      <= rep_d;
      end
    end

    assign key_repeat[g] = krep_q;
`endif
  end

`ifndef KEY_REPEAT_EN
  // Auto-repeat is not built, so key_repeat is tied low. The repeat timing
  // parameters are still referenced so that every parameter has a use.
  localparam bit REPEAT_CFG_OK = (HOLD_TICKS >= 1) && (REPEAT_TICKS >= 1);
  assign key_repeat = {NUM_KEYS{1'b0 & REPEAT_CFG_OK}};
`endif

  assign key_any = |key_state;

endmodule

// File: tb/tb_key_debounce_n.sv
module tb_key_debounce_n;

  localparam int NK = 5;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int HT = 5;
  localparam int RT = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [NK-1:0] din;
  logic [NK-1:0] key_state, key_press, key_release, key_repeat;
  logic          key_any;

  key_debounce_n #(
    .NUM_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .ACTIVE_LOW(1),
    .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .din(din),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .key_any(key_any)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  // Reference model. Each key has a debounced level. The level flips once DB
  // consecutive tick samples disagree with it. After a press is accepted, or
  // after a bounce returns to pressed, a repeat fires at the HT-th held tick
  // and then every RT-th held tick.
  logic [NK-1:0] m_s1, m_s2;
  int            m_cyc;
  bit            m_L[NK];
  bit            m_prev[NK];
  int            m_run[NK];
  int            m_k[NK];
  logic [NK-1:0] e_state, e_press, e_rel, e_rep;

  logic [4*NK:0] obs, expv;
  assign obs  = {key_state, key_press, key_release, key_repeat, key_any};
  assign expv = {e_state, e_press, e_rel, e_rep, |e_state};

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_cyc = 0;
    for (int i = 0; i < NK; i++) begin
      m_L[i] = 1'b0; m_prev[i] = 1'b0; m_run[i] = 0; m_k[i] = 0;
    end
    e_state = '0; e_press = '0; e_rel = '0; e_rep = '0;
  endtask

  task automatic model_edge();
    bit tk, smp;
    tk = (m_cyc % TD) == (TD - 1);
    e_press = '0; e_rel = '0; e_rep = '0;
    if (tk) begin
      for (int i = 0; i < NK; i++) begin
        smp = ~m_s2[i];
        if (smp != m_L[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_L[i] = smp; m_run[i] = 0;
            if (smp) begin e_press[i] = 1'b1; m_k[i] = 0; end
            else e_rel[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
          if (m_L[i]) begin
            if (!m_prev[i]) m_k[i] = 0;
            else begin
              m_k[i]++;
              if (REP_EN && m_k[i] >= HT && ((m_k[i] - HT) % RT) == 0) e_rep[i] = 1'b1;
            end
          end
        end
        m_prev[i] = smp;
        e_state[i] = m_L[i];
      end
    end
    m_s2 = m_s1; m_s1 = din; m_cyc++;
  endtask

  // Advance one clock with the model, ending at the falling edge.
  task automatic cycle();
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1; din = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_total++;
      if (obs !== '0) $display("FAIL reset_outputs: got %b required %b", obs, {(4*NK+1){1'b0}});
      else n_pass++;
    end
    model_reset();
    RESET = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      n_total++;
      if (obs !== expv) $display("FAIL idle_after_reset: got %b required %b", obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_single_press();
    int np = 0;
    din[0] = 1'b0;
    for (int c = 0; c < 20 * TD; c++) begin
      cycle();
      if (key_press[0]) np++;
      n_total++;
      if (obs !== expv) $display("FAIL single_press: got %b required %b", obs, expv);
      else n_pass++;
    end
    n_total++;
    if (np !== 1) $display("FAIL single_press_count: got %0d required 1", np);
    else n_pass++;
    n_total++;
    if ({key_state, key_any} !== {5'b00001, 1'b1})
      $display("FAIL single_press_state: got %b/%b required 00001/1", key_state, key_any);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int np = 0, nr = 0;
    din[0] = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c == TD) din[0] = 1'b0;
      cycle();
      if (key_press[0]) np++;
      if (key_release[0]) nr++;
      n_total++;
      if (obs !== expv) $display("FAIL bounce_short: got %b required %b", obs, expv);
      else n_pass++;
    end
    n_total++;
    if ({np[3:0], nr[3:0], key_state[0]} !== {4'd0, 4'd0, 1'b1})
      $display("FAIL bounce_short_pulses: got press=%0d rel=%0d state=%b required 0 0 1", np, nr, key_state[0]);
    else n_pass++;
    din[0] = 1'b1; nr = 0;
    for (int c = 0; c < 6 * TD; c++) begin
      cycle();
      if (key_release[0]) nr++;
      n_total++;
      if (obs !== expv) $display("FAIL bounce_release: got %b required %b", obs, expv);
      else n_pass++;
    end
    n_total++;
    if ({nr[3:0], key_state[0]} !== {4'd1, 1'b0})
      $display("FAIL release_count: got rel=%0d state=%b required 1 0", nr, key_state[0]);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int np = 0;
    din[1] = 1'b0;
    for (int c = 0; c < 8 * TD; c++) begin
      if (c == 2 * TD) din[1] = 1'b1;
      cycle();
      if (key_press[1]) np++;
      n_total++;
      if (obs !== expv) $display("FAIL glitch: got %b required %b", obs, expv);
      else n_pass++;
    end
    n_total++;
    if ({np[3:0], key_state[1]} !== {4'd0, 1'b0})
      $display("FAIL glitch_press: got press=%0d state=%b required 0 0", np, key_state[1]);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int p2 = -1, p4 = -1;
    din[2] = 1'b0; din[4] = 1'b0;
    for (int c = 0; c < 10 * TD; c++) begin
      cycle();
      if (key_press[2] && p2 < 0) p2 = c;
      if (key_press[4] && p4 < 0) p4 = c;
      n_total++;
      if (obs !== expv) $display("FAIL simultaneous: got %b required %b", obs, expv);
      else n_pass++;
    end
    n_total++;
    if (p2 < 0 || p2 != p4) $display("FAIL simultaneous_cycle: got key2@%0d key4@%0d required equal", p2, p4);
    else n_pass++;
    din = '1;
    for (int c = 0; c < 6 * TD; c++) begin
      cycle();
      n_total++;
      if (obs !== expv) $display("FAIL simultaneous_release: got %b required %b", obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_repeat();
    int nrep = 0, waited = 0;
    din[3] = 1'b0;
    while (!key_press[3] && waited < 15 * TD) begin
      cycle(); waited++;
      n_total++;
      if (obs !== expv) $display("FAIL repeat_accept: got %b required %b", obs, expv);
      else n_pass++;
    end
    n_total++;
    if (!key_press[3]) $display("FAIL repeat_accept_timeout: got no press in %0d cycles required press", waited);
    else n_pass++;
    for (int c = 0; c < 12 * TD; c++) begin
      cycle();
      if (key_repeat[3]) nrep++;
      n_total++;
      if (obs !== expv) $display("FAIL repeat_hold: got %b required %b", obs, expv);
      else n_pass++;
    end
    n_total++;
    if (nrep != (REP_EN ? 4 : 0)) $display("FAIL repeat_count: got %0d required %0d", nrep, REP_EN ? 4 : 0);
    else n_pass++;
    din = '1;
    for (int c = 0; c < 6 * TD; c++) begin
      cycle();
      n_total++;
      if (obs !== expv) $display("FAIL repeat_release: got %b required %b", obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    din[0] = 1'b0;
    for (int c = 0; c < 2 * TD; c++) begin
      cycle();
      n_total++;
      if (obs !== expv) $display("FAIL reset_mid_pre: got %b required %b", obs, expv);
      else n_pass++;
    end
    // Assert reset between clock edges: outputs must clear without a clock.
    #2 RESET = 1'b1;
    #1;
    n_total++;
    if (obs !== '0) $display("FAIL reset_mid_async: got %b required 0", obs);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_total++;
      if (obs !== '0) $display("FAIL reset_mid_hold: got %b required 0", obs);
      else n_pass++;
    end
    model_reset();
    RESET = 1'b0;
    // Two synchroniser stages, then ticks at edges 4, 8 and 12.
    while (!key_press[0] && waited < 40) begin
      cycle(); waited++;
      n_total++;
      if (obs !== expv) $display("FAIL reset_mid_after: got %b required %b", obs, expv);
      else n_pass++;
    end
    n_total++;
    if (waited != 3 * TD) $display("FAIL reset_reaccept_latency: got %0d cycles required %0d", waited, 3 * TD);
    else n_pass++;
    // Reset with a key in the pressed state: key_state must drop at once.
    cycle();
    #2 RESET = 1'b1;
    #1;
    n_total++;
    if (obs !== '0) $display("FAIL reset_pressed_async: got %b required 0", obs);
    else n_pass++;
    @(negedge CLK);
    din = '1;
    model_reset();
    RESET = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 2400; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (c < 800) begin
          if ($urandom_range(5) == 0) din[i] = ~din[i];
        end else begin
          if ($urandom_range(59) == 0) din[i] = ~din[i];
        end
      end
      cycle();
      n_total++;
      if (obs !== expv) $display("FAIL random: got %b required %b", obs, expv);
      else n_pass++;
    end
  endtask

  initial begin
    RESET = 1'b1;
    din = '1;
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_repeat();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
